nor_bus_wb_responder: RTL and testbench
=======================================

Name: nor_bus_wb_responder

Overview:
- Wishbone pipelined slave at the far end of the NOR controller's master port (26-bit address, 16-bit data).
- Converts each accepted single-beat Wishbone request into one timed asynchronous parallel-NOR bus cycle on the flash pins: CE#, OE#, WE#, address, and a tri-stated data bus.
- Sits between the NOR controller and the top-level flash pads.
- Handles exactly one outstanding transfer at a time.

Parameters:
- ADDRBITS, 26, width of the Wishbone and NOR address.
- DATABITS, 16, width of the data bus.
- TSETUP, 1, cycles of address/CE# setup before the OE#/WE# strobe (>=1).
- TRD, 7, cycles OE# is held low before read data is sampled (>=1).
- TWP, 4, cycles WE# is held low (>=1).
- TWH, 2, cycles of data/address hold after WE# rises (>=1).
- TOUT, 4095, RY/BY# wait limit in cycles (used only with the optional feature).

Ports:
- wb_clk_i  in  1  clock; all logic is on the rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- wb_adr_i  in  ADDRBITS  request address.
- wb_dat_i  in  DATABITS  write data.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_stb_i  in  1  request strobe.
- wb_cyc_i  in  1  bus cycle valid.
- wb_ack_o  out  1  transfer complete; one-cycle pulse.
- wb_dat_o  out  DATABITS  read data; valid while wb_ack_o is high.
- wb_stall_o  out  1  request not accepted.
- wb_err_o  out  1  transfer failed; one-cycle pulse (optional feature only, otherwise tied 0).
- nor_addr_o  out  ADDRBITS  flash address.
- nor_data_o  out  DATABITS  flash write data.
- nor_data_oe_o  out  1  pad output enable for nor_data_o.
- nor_data_i  in  DATABITS  flash read data from the pads.
- nor_ce_n_o  out  1  chip enable, active-low.
- nor_oe_n_o  out  1  output enable, active-low.
- nor_we_n_o  out  1  write enable, active-low.
- nor_ryby_n_i  in  1  flash ready/busy#, asynchronous.

Behaviour:
- Reset values (async, asserted while wb_rst_i=0):
  - Wishbone: wb_ack_o=0, wb_err_o=0, wb_stall_o=1, wb_dat_o=0.
  - Flash pins: nor_ce_n_o=1, nor_oe_n_o=1, nor_we_n_o=1, nor_data_oe_o=0, nor_addr_o=0, nor_data_o=0.
  - FSM returns to IDLE.
  - Reset during a flash cycle aborts it immediately; the pins go inactive the same instant.
- Outputs: all registered, no combinational path from the Wishbone inputs to any output.
- FSM states: IDLE, SETUP, READ, WRITE, HOLD, [WAIT], ACK.
  - A single down-counter is loaded with (param-1) on each state entry.
  - The state advances when the counter reaches 0.
- IDLE:
  - wb_stall_o=0.
  - Request is accepted when wb_cyc_i & wb_stb_i are high at a clock edge.
  - On acceptance: latch address, data and we; go to SETUP; wb_stall_o=1 from the next cycle.
  - wb_stall_o stays 1 in every other state.
- SETUP (TSETUP cycles):
  - nor_ce_n_o=0, nor_addr_o=latched address.
  - On a write, nor_data_oe_o=1 and nor_data_o=latched data.
  - Exits to READ or WRITE.
- READ (TRD cycles):
  - nor_oe_n_o=0.
  - nor_data_i is captured into wb_dat_o on the final edge.
  - Exits to ACK.
- WRITE (TWP cycles): nor_we_n_o=0, then exits to HOLD.
- HOLD (TWH cycles):
  - nor_we_n_o=1, CE#, address and data still driven.
  - Exits to ACK, or to WAIT when the optional feature is compiled in.
- ACK (1 cycle):
  - wb_ack_o=1; all strobes inactive, nor_data_oe_o=0.
  - Next state is IDLE.
  - wb_dat_o holds its value until the next read capture.
- Latency, counted from the acceptance edge to the cycle in which ack is high:
  - read: TSETUP+TRD+1 (defaults: 9).
  - write: TSETUP+TWP+TWH+1 (defaults: 8).
  - Throughput is one transfer per latency+1 cycles.
- wb_cyc_i dropped mid-transfer:
  - The flash cycle completes with its full timing; strobes never glitch.
  - wb_ack_o and wb_err_o are suppressed for that transfer.
- Strobe/data-enable ordering:
  - OE# and WE# are never both low.
  - nor_data_oe_o is never 1 while nor_oe_n_o=0.
  - OE#/WE# are only low while CE# is low.
- wb_stb_i while stalled: ignored; the request is not queued.

Optional Feature:
- Macro: NOR_RYBY_WAIT_EN.
- With the macro defined:
  - nor_ryby_n_i passes through a 2-flop synchroniser.
  - After HOLD, the FSM enters WAIT with CE# high and the data bus released.
  - It stays in WAIT until the synchronised RY/BY# = 1, then goes to ACK.
  - If RY/BY# stays 0 for TOUT cycles, it goes to IDLE pulsing wb_err_o=1 for one cycle instead of wb_ack_o.
  - Reads are unaffected.
- Without the macro: nor_ryby_n_i is unused, there is no WAIT state, and wb_err_o is tied 0.

Test Plan:
- Reset: hold wb_rst_i=0 and toggle the Wishbone inputs -> CE#/OE#/WE#=1, nor_data_oe_o=0, wb_stall_o=1, wb_ack_o=0; after release, wb_stall_o=0 next cycle.
- Read: read at 0x0123456 with the flash model returning 0xBEEF -> nor_addr_o=0x0123456, OE# low exactly 7 cycles, wb_ack_o high 9 cycles after acceptance with wb_dat_o=0xBEEF.
- Write: write 0xA5A5 to 0x0000AAA -> WE# low 4 cycles, nor_data_o=0xA5A5 with nor_data_oe_o=1 from SETUP through HOLD, ack 8 cycles after acceptance.
- Back-to-back: write followed by read, stb held high -> second request accepted only when wb_stall_o=0 in IDLE; no overlap of the two flash cycles.
- Abort and reset: drop wb_cyc_i two cycles into a read -> full 7-cycle OE# pulse, no ack. Assert reset during WRITE -> WE#/CE# go high asynchronously.
- NOR_RYBY_WAIT_EN: RY/BY# low 20 cycles after HOLD -> ack 3 cycles after it rises (2 synchroniser cycles + ACK cycle). RY/BY# stuck low -> wb_err_o pulse after 4095 cycles, no ack.

Source files
------------

// File: rtl/nor_bus_wb_responder.sv
// rtl/nor_bus_wb_responder.sv - Wishbone pipelined slave driving one timed async parallel-NOR cycle per request
//
// Purpose: accepts one single-beat Wishbone request at a time and turns it into
// a CE#/OE#/WE# strobed NOR bus cycle with programmable setup, strobe and hold
// lengths. Optional RY/BY# wait after writes: define NOR_RYBY_WAIT_EN.
//
// Ports:
//   wb_clk_i, wb_rst_i (async, active-low)
//   wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i   request side
//   wb_ack_o, wb_dat_o, wb_stall_o, wb_err_o          response side
//   nor_addr_o, nor_data_o, nor_data_oe_o, nor_data_i flash address/data pads
//   nor_ce_n_o, nor_oe_n_o, nor_we_n_o                flash strobes
//   nor_ryby_n_i                                      flash ready/busy#

module nor_bus_wb_responder #(
    parameter int ADDRBITS = 26,
    parameter int DATABITS = 16,
    parameter int TSETUP   = 1,
    parameter int TRD      = 7,
    parameter int TWP      = 4,
    parameter int TWH      = 2,
    parameter int TOUT     = 4095
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [ADDRBITS-1:0] wb_adr_i,
    input  logic [DATABITS-1:0] wb_dat_i,
    input  logic                wb_we_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic                wb_ack_o,
    output logic [DATABITS-1:0] wb_dat_o,
    output logic                wb_stall_o,
    output logic                wb_err_o,
    output logic [ADDRBITS-1:0] nor_addr_o,
    output logic [DATABITS-1:0] nor_data_o,
    output logic                nor_data_oe_o,
    input  logic [DATABITS-1:0] nor_data_i,
    output logic                nor_ce_n_o,
    output logic                nor_oe_n_o,
    output logic                nor_we_n_o,
    input  logic                nor_ryby_n_i
);

    localparam int M1 = (TSETUP > TRD) ? TSETUP : TRD;
    localparam int M2 = (M1 > TWP) ? M1 : TWP;
    localparam int M3 = (M2 > TWH) ? M2 : TWH;
`ifdef NOR_RYBY_WAIT_EN
    localparam int M4 = (M3 > TOUT) ? M3 : TOUT;
`else
    localparam int M4 = M3;
    localparam int unused_tout = TOUT;
`endif
    localparam int CW = (M4 > 1) ? $clog2(M4) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4,
        S_ACK   = 3'd5
`ifdef NOR_RYBY_WAIT_EN
        , S_WAIT = 3'd6
`endif
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_next;
    logic          accept;
    logic          we_q;
    logic          live_q;
    logic          live_now;
    logic          we_sel;
    logic          drive_bus;

`ifdef NOR_RYBY_WAIT_EN
    logic ryby_s1, ryby_s2;
    logic timeout;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ryby_s1 <= 1'b0;
            ryby_s2 <= 1'b0;
        end else begin
            ryby_s1 <= nor_ryby_n_i;
            ryby_s2 <= ryby_s1;
        end
    end
`else
    logic unused_ryby;
    assign unused_ryby = nor_ryby_n_i;
`endif

    // The stall flop is part of the accept condition so the first edge after
    // reset release (stall still 1) cannot take a request.
    always_comb begin
        next_state = state;
        cnt_next   = (cnt != '0) ? cnt - 1'b1 : '0;
        accept     = 1'b0;
`ifdef NOR_RYBY_WAIT_EN
        timeout    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!wb_stall_o && wb_cyc_i && wb_stb_i) begin
                    accept     = 1'b1;
                    next_state = S_SETUP;
                    cnt_next   = CW'(TSETUP - 1);
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    next_state = we_q ? S_WRITE : S_READ;
                    cnt_next   = we_q ? CW'(TWP - 1) : CW'(TRD - 1);
                end
            end
            S_READ: begin
                if (cnt == '0) next_state = S_ACK;
            end
            S_WRITE: begin
                if (cnt == '0) begin
                    next_state = S_HOLD;
                    cnt_next   = CW'(TWH - 1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
`ifdef NOR_RYBY_WAIT_EN
                    next_state = S_WAIT;
                    cnt_next   = CW'(TOUT - 1);
`else
                    next_state = S_ACK;
`endif
                end
            end
`ifdef NOR_RYBY_WAIT_EN
            S_WAIT: begin
                if (ryby_s2) begin
                    next_state = S_ACK;
                end else if (cnt == '0) begin
                    next_state = S_IDLE;
                    timeout    = 1'b1;
                end
            end
`endif
            S_ACK:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // A transfer stays "live" only while cyc is held; once dropped, the flash
    // cycle still runs to completion but its ack/err is swallowed.
    assign live_now  = live_q && wb_cyc_i;
    assign we_sel    = accept ? wb_we_i : we_q;
    assign drive_bus = (next_state == S_SETUP) || (next_state == S_READ) ||
                       (next_state == S_WRITE) || (next_state == S_HOLD);

    // Pin registers are loaded from the next state, so each pin changes on the
    // same edge as the state it belongs to and never through a comb path.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state         <= S_IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            live_q        <= 1'b0;
            wb_ack_o      <= 1'b0;
            wb_err_o      <= 1'b0;
            wb_stall_o    <= 1'b1;
            wb_dat_o      <= '0;
            nor_addr_o    <= '0;
            nor_data_o    <= '0;
            nor_data_oe_o <= 1'b0;
            nor_ce_n_o    <= 1'b1;
            nor_oe_n_o    <= 1'b1;
            nor_we_n_o    <= 1'b1;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;

            if (accept) begin
                we_q       <= wb_we_i;
                nor_addr_o <= wb_adr_i;
                if (wb_we_i) nor_data_o <= wb_dat_i;
            end

            if (accept)         live_q <= 1'b1;
            else if (!wb_cyc_i) live_q <= 1'b0;

            if (state == S_READ && cnt == '0) wb_dat_o <= nor_data_i;

            wb_stall_o    <= (next_state != S_IDLE);
            wb_ack_o      <= (next_state == S_ACK) && live_now;
`ifdef NOR_RYBY_WAIT_EN
            wb_err_o      <= timeout && live_now;
`else
            wb_err_o      <= 1'b0;
`endif
            nor_ce_n_o    <= !drive_bus;
            nor_oe_n_o    <= !(next_state == S_READ);
            nor_we_n_o    <= !(next_state == S_WRITE);
            nor_data_oe_o <= we_sel && ((next_state == S_SETUP) ||
                                        (next_state == S_WRITE) ||
                                        (next_state == S_HOLD));
        end
    end

endmodule

// File: tb/tb_nor_bus_wb_responder.sv
// tb/tb_nor_bus_wb_responder.sv - self-checking bench for nor_bus_wb_responder

module tb_nor_bus_wb_responder;

    localparam int AW     = 26;
    localparam int DW     = 16;
    localparam int TSETUP = 1;
    localparam int TRD    = 7;
    localparam int TWP    = 4;
    localparam int TWH    = 2;
    localparam int TOUT   = 4095;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wb_adr = '0;
    logic [DW-1:0] wb_dat = '0;
    logic          wb_we = 1'b0;
    logic          wb_stb = 1'b0;
    logic          wb_cyc = 1'b0;
    logic          wb_ack_o;
    logic [DW-1:0] wb_dat_o;
    logic          wb_stall_o;
    logic          wb_err_o;
    logic [AW-1:0] nor_addr_o;
    logic [DW-1:0] nor_data_o;
    logic          nor_data_oe_o;
    logic [DW-1:0] nor_data_i = '0;
    logic          nor_ce_n_o;
    logic          nor_oe_n_o;
    logic          nor_we_n_o;
    logic          nor_ryby_n_i = 1'b1;

    int errors = 0;
    int checks = 0;

    nor_bus_wb_responder #(
        .ADDRBITS(AW), .DATABITS(DW), .TSETUP(TSETUP), .TRD(TRD),
        .TWP(TWP), .TWH(TWH), .TOUT(TOUT)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst_n),
        .wb_adr_i      (wb_adr),
        .wb_dat_i      (wb_dat),
        .wb_we_i       (wb_we),
        .wb_stb_i      (wb_stb),
        .wb_cyc_i      (wb_cyc),
        .wb_ack_o      (wb_ack_o),
        .wb_dat_o      (wb_dat_o),
        .wb_stall_o    (wb_stall_o),
        .wb_err_o      (wb_err_o),
        .nor_addr_o    (nor_addr_o),
        .nor_data_o    (nor_data_o),
        .nor_data_oe_o (nor_data_oe_o),
        .nor_data_i    (nor_data_i),
        .nor_ce_n_o    (nor_ce_n_o),
        .nor_oe_n_o    (nor_oe_n_o),
        .nor_we_n_o    (nor_we_n_o),
        .nor_ryby_n_i  (nor_ryby_n_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: one transaction described by its acceptance edge number;
    // every pin is a function of how many edges have passed since then.
    int            ecount = 0;
    int            t_acc = 0;
    bit            have = 1'b0;
    bit            m_we = 1'b0;
    bit            live = 1'b0;
    bit            fresh = 1'b1;
    logic [DW-1:0] m_rd = '0;
    logic [AW-1:0] m_adr = '0;
    logic [DW-1:0] m_wd = '0;

    function automatic int lat(input bit we);
        return we ? (TSETUP + TWP + TWH + 1) : (TSETUP + TRD + 1);
    endfunction

    function automatic bit in_txn();
        return have && ((ecount - t_acc) <= lat(m_we) - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have  = 1'b0;
            fresh = 1'b1;
            live  = 1'b0;
            m_rd  = '0;
        end else begin
            bit stalled;
            int k;
            stalled = fresh || in_txn();
            ecount++;
            fresh = 1'b0;
            if (!stalled && wb_cyc && wb_stb) begin
                have  = 1'b1;
                t_acc = ecount;
                m_we  = wb_we;
                m_adr = wb_adr;
                m_wd  = wb_dat;
                live  = 1'b1;
            end else if (in_txn()) begin
                k = ecount - t_acc;
                if (!wb_cyc) live = 1'b0;
                if (!m_we && k == TSETUP + TRD) m_rd = nor_data_i;
            end
        end
    end

    always @(negedge clk) begin
        int k;
        int l;
        bit t;
        bit e_ce_n, e_oe_n, e_we_n, e_doe, e_ack, e_stall;
        logic [79:0] g, e;
        k = ecount - t_acc;
        l = lat(m_we);
        t = in_txn();
        e_ce_n  = !(t && k <= l - 2);
        e_oe_n  = !(t && !m_we && k >= TSETUP && k < TSETUP + TRD);
        e_we_n  = !(t && m_we && k >= TSETUP && k < TSETUP + TWP);
        e_doe   = t && m_we && (k <= l - 2);
        e_ack   = t && (k == l - 1) && live;
        e_stall = fresh || t;
        g = {nor_ce_n_o, nor_oe_n_o, nor_we_n_o, nor_data_oe_o, wb_ack_o, wb_stall_o,
             wb_err_o, wb_dat_o, (e_ce_n ? {AW{1'b0}} : nor_addr_o),
             (e_doe ? nor_data_o : {DW{1'b0}})};
        e = {e_ce_n, e_oe_n, e_we_n, e_doe, e_ack, e_stall, 1'b0, m_rd,
             (e_ce_n ? {AW{1'b0}} : m_adr), (e_doe ? m_wd : {DW{1'b0}})};
        chk("model_cycle", g, e);
    end

    task automatic run_xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int drop_at, output int oe_low, output int we_low,
                            output int doe_n, output int ack_cyc,
                            output logic [DW-1:0] ack_dat, output bit pins_ok);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = a; wb_dat = d;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        oe_low = 0; we_low = 0; doe_n = 0; ack_cyc = 0; ack_dat = '0; pins_ok = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!nor_oe_n_o) oe_low++;
            if (!nor_we_n_o) we_low++;
            if (nor_data_oe_o) begin
                doe_n++;
                if (nor_data_o !== d) pins_ok = 1'b0;
            end
            if (!nor_ce_n_o && nor_addr_o !== a) pins_ok = 1'b0;
            if (wb_ack_o) begin
                ack_cyc = i;
                ack_dat = wb_dat_o;
            end
            @(posedge clk); #1;
            if (i == drop_at) wb_cyc = 1'b0;
        end
        wb_cyc = 1'b1;
    endtask

    initial begin
        int oe_low, we_low, doe_n, ack_cyc, a1, a2, first_oe;
        logic [DW-1:0] ack_dat;
        bit pins_ok;

        // Reset with inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = i[0];
            wb_adr = AW'($urandom); wb_dat = DW'($urandom);
        end
        chk("rst_pins", {nor_ce_n_o, nor_oe_n_o, nor_we_n_o, nor_data_oe_o}, 4'b1110);
        chk("rst_wb", {wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o}, {3'b100, 16'h0});
        chk("rst_bus", {nor_addr_o, nor_data_o}, '0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("stall_after_rst", wb_stall_o, 1'b0);

        // Directed read
        nor_data_i = 16'hBEEF;
        run_xfer(1'b0, 26'h0123456, 16'h0, 0, oe_low, we_low, doe_n, ack_cyc, ack_dat, pins_ok);
        chk("rd_addr", pins_ok, 1'b1);
        chk("rd_oe_low", oe_low, 7);
        chk("rd_we_low", we_low, 0);
        chk("rd_ack_cycle", ack_cyc, 9);
        chk("rd_data", ack_dat, 16'hBEEF);

        // Directed write
        run_xfer(1'b1, 26'h0000AAA, 16'hA5A5, 0, oe_low, we_low, doe_n, ack_cyc, ack_dat, pins_ok);
        chk("wr_pins", pins_ok, 1'b1);
        chk("wr_we_low", we_low, 4);
        chk("wr_oe_low", oe_low, 0);
        chk("wr_doe_cycles", doe_n, 7);
        chk("wr_ack_cycle", ack_cyc, 8);

        // Abort: cyc dropped two cycles into a read
        nor_data_i = 16'h1234;
        run_xfer(1'b0, 26'h0200000, 16'h0, 2, oe_low, we_low, doe_n, ack_cyc, ack_dat, pins_ok);
        chk("abort_oe_low", oe_low, 7);
        chk("abort_no_ack", ack_cyc, 0);

        // Back-to-back: write then read with stb held
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 26'h0000100; wb_dat = 16'h5A5A;
        @(posedge clk); #1;
        wb_we = 1'b0; wb_adr = 26'h0000200;
        a1 = 0; a2 = 0; first_oe = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (wb_ack_o) begin
                if (a1 == 0) a1 = i;
                else a2 = i;
            end
            if (!nor_oe_n_o && first_oe == 0) first_oe = i;
            @(posedge clk); #1;
            if (i == 9) wb_stb = 1'b0;
        end
        chk("b2b_ack1", a1, 8);
        chk("b2b_ack2", a2, 18);
        chk("b2b_first_oe", first_oe, 11);

        // Reset asserted in the middle of WRITE
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 26'h0001000; wb_dat = 16'hC3C3;
        @(posedge clk); #1;
        wb_stb = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        chk("wr_we_before_rst", {nor_ce_n_o, nor_we_n_o}, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_pins", {nor_ce_n_o, nor_we_n_o, nor_oe_n_o, nor_data_oe_o}, 4'b1110);
        chk("rst_async_stall", wb_stall_o, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            wb_cyc     = ($urandom_range(0, 15) != 0);
            wb_stb     = ($urandom_range(0, 2) != 0);
            wb_we      = $urandom_range(0, 1) == 1;
            wb_adr     = AW'($urandom);
            wb_dat     = DW'($urandom);
            nor_data_i = DW'($urandom);
            @(posedge clk); #1;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
